// File: rtl/envelope_follower.sv
// Envelope follower: rectifies each audio sample and slews a level toward it, plus hysteretic gate and peak meter.
// Latency: level reflects the sample taken on the same edge; gate lags level by one edge; peak updates on the same edge.
// Backpressure: none; one sample is consumed on every sample_clock edge.
module envelope_follower #(
  parameter int BITDEPTH     = 14,
  parameter int HYST         = 8,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic                sample_clock,
  input  logic                rst,
  input  logic [BITDEPTH-1:0] in,
  input  logic [7:0]          attack,
  input  logic [7:0]          release_rate,
  input  logic [7:0]          threshold,
  input  logic                peak_clear,
  output logic [7:0]          level,
  output logic                gate,
  output logic [7:0]          peak
);

  // Hold counter only needs to reach HOLD_SAMPLES-1; keep at least one bit.
  localparam int HCW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_SAMPLES > 0) ? HOLD_SAMPLES - 1 : 0);
  localparam logic [7:0] HYST_W = 8'(HYST);
  localparam logic [BITDEPTH-1:0] MOST_NEG = {1'b1, {(BITDEPTH-1){1'b0}}};

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2
  } gate_state_t;

  gate_state_t     state;
  logic [HCW-1:0]  hold_cnt;
  logic [15:0]     acc;
  logic [15:0]     acc_nxt;
  logic [15:0]     tgt_full;
  logic [16:0]     tgt_ext;
  logic [16:0]     acc_up;
  logic [16:0]     acc_dn;
  logic [BITDEPTH-2:0] neg_mag;
  logic [BITDEPTH-2:0] mag;
  logic [7:0]      target;
  logic [7:0]      close_th;

  assign level = acc[15:8];

  // Rectify: the most-negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    neg_mag = -in[BITDEPTH-2:0];
    if (in == MOST_NEG) begin
      mag = '1;
    end else if (in[BITDEPTH-1]) begin
      mag = neg_mag;
    end else begin
      mag = in[BITDEPTH-2:0];
    end
    target = 8'(mag >> (BITDEPTH - 9));
  end

  // Slew toward the target with a 17-bit intermediate so a step can never wrap or overshoot.
  always_comb begin
    tgt_full = {target, 8'h00};
    tgt_ext  = {1'b0, tgt_full};
    acc_up   = {1'b0, acc} + {9'd0, attack} + 17'd1;
    acc_dn   = {1'b0, acc} - {9'd0, release_rate} - 17'd1;
    acc_nxt  = acc;
    if (acc < tgt_full) begin
      acc_nxt = (acc_up >= tgt_ext) ? tgt_full : acc_up[15:0];
    end else if (acc > tgt_full) begin
      acc_nxt = (acc_dn[16] || (acc_dn < tgt_ext)) ? tgt_full : acc_dn[15:0];
    end
  end

  // Close threshold sits HYST below the open threshold, floored at zero.
  always_comb begin
    close_th = (threshold > HYST_W) ? (threshold - HYST_W) : 8'd0;
  end

  // Envelope accumulator register.
  always_ff @(posedge sample_clock or negedge rst) begin
    if (!rst) begin
      acc <= 16'd0;
    end else begin
      acc <= acc_nxt;
    end
  end

  // Peak meter: a clear loads the current target so the sample on that edge is not lost.
  always_ff @(posedge sample_clock or negedge rst) begin
    if (!rst) begin
      peak <= 8'd0;
    end else if (peak_clear) begin
      peak <= target;
    end else if (target > peak) begin
      peak <= target;
    end
  end

  // Gate FSM on the registered level; gate is driven from the same register update.
  always_ff @(posedge sample_clock or negedge rst) begin
    if (!rst) begin
      state    <= CLOSED;
      hold_cnt <= '0;
      gate     <= 1'b0;
    end else begin
      case (state)
        CLOSED: begin
          if (level >= threshold) begin
            state <= OPEN;
            gate  <= 1'b1;
          end else begin
            gate  <= 1'b0;
          end
        end
        OPEN: begin
          gate <= 1'b1;
          if (level < close_th) begin
            if (HOLD_SAMPLES == 0) begin
              state <= CLOSED;
              gate  <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (level >= close_th) begin
            state <= OPEN;
            gate  <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= CLOSED;
            gate  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
            gate     <= 1'b1;
          end
        end
        default: begin
          state <= CLOSED;
          gate  <= 1'b0;
        end
      endcase
    end
  end

endmodule
